// File: rtl/mem_mmio_bridge.sv
// CPU memory bridge: word RAM at 0x0xxx_xxxx plus MMIO registers (LED, cycle
// counter, periodic timer, status, console TX FIFO) at 0xF000_00xx.
module mem_mmio_bridge #(
  parameter int RAM_ADDR_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  // Word addresses (byte address >> 2) of the MMIO registers.
  localparam logic [29:0] LED_WA  = 30'h3C00_0000;
  localparam logic [29:0] CYC_WA  = 30'h3C00_0001;
  localparam logic [29:0] TIM_WA  = 30'h3C00_0002;
  localparam logic [29:0] STAT_WA = 30'h3C00_0003;
  localparam logic [29:0] TX_WA   = 30'h3C00_0004;

  logic [31:0] ram [2**RAM_ADDR_W];
  logic [7:0]  fifoMem [FIFO_DEPTH];

  logic [31:0] cycleCnt, tmrCount, tmrReload;
  logic        txOvf;
  logic [PW-1:0] rdPtr, wrPtr, rdNext;
  logic [CW-1:0] fifoCnt, cntNext;

  logic [29:0] wordAddr;
  logic [RAM_ADDR_W-1:0] ramIdx;
  logic isRam, wrLed, wrCyc, wrTim, wrStat, wrTx;
  logic fifoFull, fifoEmpty, pop, pushOk, expSet;

  assign wordAddr  = mem_addr[31:2];
  assign ramIdx    = mem_addr[RAM_ADDR_W+1:2];
  assign isRam     = (mem_addr[31:28] == 4'h0);
  assign wrLed     = mem_wr_ena && (wordAddr == LED_WA);
  assign wrCyc     = mem_wr_ena && (wordAddr == CYC_WA);
  assign wrTim     = mem_wr_ena && (wordAddr == TIM_WA);
  assign wrStat    = mem_wr_ena && (wordAddr == STAT_WA);
  assign wrTx      = mem_wr_ena && (wordAddr == TX_WA);

  assign fifoFull  = (fifoCnt == FULL_CNT);
  assign fifoEmpty = (fifoCnt == '0);
  assign pop       = tx_valid && tx_ready;
  assign pushOk    = wrTx && (!fifoFull || pop);
  assign rdNext    = pop ? rdPtr + PW'(1) : rdPtr;
  assign expSet    = !wrTim && (tmrCount == 32'd1);

  always_comb begin
    cntNext = fifoCnt;
    if (pushOk && !pop)      cntNext = fifoCnt + CW'(1);
    else if (pop && !pushOk) cntNext = fifoCnt - CW'(1);
  end

  always_comb begin
    mem_rd_data = '0;
    if (isRam) mem_rd_data = ram[ramIdx];
    else begin
      case (wordAddr)
        LED_WA:  mem_rd_data = {24'h0, leds};
        CYC_WA:  mem_rd_data = cycleCnt;
        TIM_WA:  mem_rd_data = tmrCount;
        STAT_WA: mem_rd_data = {28'h0, txOvf, fifoEmpty, fifoFull, timer_irq};
        default: mem_rd_data = '0;
      endcase
    end
  end

  // Storage arrays are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_wr_ena && isRam) ram[ramIdx] <= mem_wr_data;
    if (pushOk) fifoMem[wrPtr] <= mem_wr_data[7:0];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      leds      <= '0;
      cycleCnt  <= '0;
      tmrCount  <= '0;
      tmrReload <= '0;
      timer_irq <= 1'b0;
      txOvf     <= 1'b0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCnt   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      if (wrLed) leds <= mem_wr_data[7:0];
      cycleCnt <= wrCyc ? '0 : cycleCnt + 32'd1;

      // Count shows 0 for one cycle after expiry, then reloads.
      if (wrTim) begin
        tmrCount  <= mem_wr_data;
        tmrReload <= mem_wr_data;
      end else if (tmrCount == 32'd1) tmrCount <= '0;
      else if (tmrCount == 32'd0)     tmrCount <= tmrReload;
      else                            tmrCount <= tmrCount - 32'd1;

      if (expSet)                          timer_irq <= 1'b1;
      else if (wrStat && mem_wr_data[0])   timer_irq <= 1'b0;

      if (wrTx && fifoFull && !pop)        txOvf <= 1'b1;
      else if (wrStat && mem_wr_data[3])   txOvf <= 1'b0;

      if (pushOk) wrPtr <= wrPtr + PW'(1);
      rdPtr    <= rdNext;
      fifoCnt  <= cntNext;
      tx_valid <= (cntNext != '0);
      // A byte landing in the slot that becomes head is forwarded directly.
      tx_data  <= (pushOk && (wrPtr == rdNext)) ? mem_wr_data[7:0] : fifoMem[rdNext];
    end
  end
endmodule

// File: tb/tb_mem_mmio_bridge.sv
// Randomized bench for mem_mmio_bridge against a queue/array reference model.
module tb_mem_mmio_bridge;
  localparam int AW = 8;
  localparam int D  = 4;
  localparam logic [31:0] LED = 32'hF000_0000, CYC = 32'hF000_0004,
                          TIM = 32'hF000_0008, STAT = 32'hF000_000C,
                          TX  = 32'hF000_0010, UNM = 32'hF000_0020;

  logic clk = 1'b0, rstb = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic we = 1'b0, rdy = 1'b0;
  logic [31:0] rdData;
  logic [7:0] leds, txData;
  logic irq, txValid;

  mem_mmio_bridge #(.RAM_ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rstb(rstb), .mem_addr(addr), .mem_wr_data(wd), .mem_wr_ena(we),
    .mem_rd_data(rdData), .leds(leds), .timer_irq(irq), .tx_valid(txValid),
    .tx_data(txData), .tx_ready(rdy));

  always #5 clk = ~clk;

  int nChk = 0, nFail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mRam [2**AW];
  bit          mRamV [2**AW];
  logic [7:0]  mLed;
  logic [31:0] mCyc, mCnt, mRel;
  bit          mExp, mOvf;
  logic [7:0]  mQ [$];

  function automatic void mReset();
    mLed = 0; mCyc = 0; mCnt = 0; mRel = 0; mExp = 0; mOvf = 0;
    mQ.delete();
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a, output bit known);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    known = 1;
    if (a[31:28] == 4'h0) begin
      known = mRamV[a[AW+1:2]];
      return mRam[a[AW+1:2]];
    end
    case (wa)
      LED:  return {24'h0, mLed};
      CYC:  return mCyc;
      TIM:  return mCnt;
      STAT: return {28'h0, mOvf, mQ.size() == 0, mQ.size() == D, mExp};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void mStep(input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic r);
    logic [31:0] wa;
    bit pop, tx, set;
    int sz;
    wa  = {a[31:2], 2'b00};
    sz  = mQ.size();
    pop = (sz != 0) && r;
    tx  = w && (wa == TX);
    set = 0;
    if (w && a[31:28] == 4'h0) begin
      mRam[a[AW+1:2]] = d;
      mRamV[a[AW+1:2]] = 1;
    end
    if (w && wa == LED) mLed = d[7:0];
    mCyc = (w && wa == CYC) ? 32'h0 : mCyc + 1;
    if (w && wa == TIM) begin mCnt = d; mRel = d; end
    else if (mCnt == 1) begin mCnt = 0; set = 1; end
    else if (mCnt == 0) mCnt = mRel;
    else mCnt = mCnt - 1;
    if (set) mExp = 1;
    else if (w && wa == STAT && d[0]) mExp = 0;
    if (tx && sz == D && !pop) mOvf = 1;
    else if (w && wa == STAT && d[3]) mOvf = 0;
    if (pop) void'(mQ.pop_front());
    if (tx && (sz < D || pop)) mQ.push_back(d[7:0]);
  endfunction

  task automatic chkOuts();
    chk("leds", leds, mLed);
    chk("irq", irq, mExp);
    chk("tx_valid", txValid, mQ.size() != 0);
    if (mQ.size() != 0) chk("tx_data", txData, mQ[0]);
  endtask

  // One bus cycle: check the combinational read, clock, then check registered outputs.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    logic [31:0] e;
    bit k;
    addr = a; wd = d; we = w; rdy = r;
    #1;
    e = mRead(a, k);
    if (k) chk("rd", rdData, e);
    @(posedge clk);
    mStep(a, d, w, r);
    #1;
    chkOuts();
  endtask

  task automatic rdConst(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0; wd = '0;
    #1;
    chk(tag, rdData, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < 2**AW; i++) mRamV[i] = 0;
    mReset();
    #12;
    chk("rst_leds", leds, 8'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_txv", txValid, 1'b0);
    chk("rst_txd", txData, 8'h0);
    @(posedge clk); #1;
    rstb = 1'b1;

    // RAM write and alias read
    cyc(32'h0000_0010, 32'hDEAD_BEEF, 1, 0);
    rdConst("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rdConst("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
    cyc(32'h0000_0412, 0, 0, 0);

    // Timer countdown, expiry, reload, W1C
    cyc(TIM, 3, 1, 0);
    for (int i = 0; i < 3; i++) cyc(TIM, 0, 0, 0);
    chk("irq_set", irq, 1'b1);
    rdConst("tim_zero", TIM, 32'h0);
    cyc(TIM, 0, 0, 0);
    rdConst("tim_reload", TIM, 32'h3);
    cyc(STAT, 1, 1, 0);
    chk("irq_clr", irq, 1'b0);
    cyc(TIM, 0, 1, 0);

    // FIFO fill with overflow, then drain
    cyc(STAT, 9, 1, 0);
    for (int i = 0; i < 5; i++) cyc(TX, 32'h41 + i, 1, 0);
    rdConst("stat_full_ovf", STAT, 32'hA);
    for (int i = 0; i < 5; i++) cyc(UNM, 0, 0, 1);
    rdConst("stat_empty_ovf", STAT, 32'hC);

    // Full FIFO with simultaneous push and pop
    cyc(STAT, 8, 1, 0);
    for (int i = 0; i < 4; i++) cyc(TX, 32'h61 + i, 1, 0);
    cyc(TX, 32'h65, 1, 1);
    rdConst("stat_still_full", STAT, 32'h2);
    for (int i = 0; i < 5; i++) cyc(UNM, 0, 0, 1);

    // LED, unmapped read, cycle clear
    cyc(LED, 32'h5A, 1, 0);
    rdConst("unmapped", UNM, 32'h0);
    chk("leds_5a", leds, 8'h5A);
    cyc(CYC, 32'h1234, 1, 0);
    rdConst("cyc_cleared", CYC, 32'h0);
    cyc(CYC, 0, 0, 0);

    // Async reset mid-drain with timer running
    cyc(TIM, 5, 1, 0);
    for (int i = 0; i < 3; i++) cyc(TX, 32'h70 + i, 1, 0);
    cyc(UNM, 0, 0, 1);
    rstb = 1'b0; we = 1'b0;
    #2;
    chk("mid_rst_leds", leds, 8'h0);
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_txv", txValid, 1'b0);
    chk("mid_rst_txd", txData, 8'h0);
    mReset();
    @(posedge clk); #1;
    rstb = 1'b1;
    rdConst("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    rdConst("tim_after_rst", TIM, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      d = $urandom;
      case ($urandom_range(0, 7))
        0, 1: a = {4'h0, 28'($urandom)};
        2: a = LED;
        3: a = CYC;
        4: begin a = TIM; d = $urandom_range(0, 6); end
        5: a = STAT;
        6: a = TX;
        default: a = ($urandom_range(0, 1) == 0) ? 32'hF000_0000 + 4 * $urandom_range(5, 40)
                                                 : {4'h8, 28'($urandom)};
      endcase
      a[1:0] = 2'($urandom);
      cyc(a, d, ($urandom_range(0, 3) != 0) && !(a == CYC && $urandom_range(0, 7) != 0),
          $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChk, nFail);
    $finish;
  end
endmodule
